// File: rtl/except_ctrl.sv
// MEM-stage exception initiator: prioritises exception flags and interrupts,
// feeds CP0, flushes the pipeline and hands the redirect target to fetch.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_hw_i,
    output logic [5:0]  int_o,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_daddr_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o,
    input  logic        new_pc_ready_i
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_t                        state_q;
    logic                          new_pc_valid_q;
    logic [31:0]                   new_pc_q;
    logic [31:0]                   new_pc_d;
    logic [SYNC_STAGES-1:0][5:0]   sync_q;

    logic [31:0] eff_status;
    logic [31:0] eff_cause;
    logic [31:0] eff_epc;
    logic        int_pending;
    logic        take;
    logic [4:0]  exc_code;
    logic [31:0] bad_vaddr;
    logic        unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], int_hw_i};
        end
    end

    assign int_o = sync_q[SYNC_STAGES-1];

    // An MTC0 in flight this cycle must be seen before CP0 has committed it.
    always_comb begin
        eff_status = status_i;
        eff_cause  = cause_i;
        eff_epc    = epc_i;
        if (cp0_we_i) begin
            if (cp0_waddr_i == ADDR_STATUS) eff_status = cp0_wdata_i;
            if (cp0_waddr_i == ADDR_CAUSE)  eff_cause[9:8] = cp0_wdata_i[9:8];
            if (cp0_waddr_i == ADDR_EPC)    eff_epc = cp0_wdata_i;
        end
    end

    assign int_pending = eff_status[0] & ~eff_status[1]
                       & (|(eff_cause[15:8] & eff_status[15:8]));
    assign take = rst & (state_q == IDLE) & mem_valid_i & ~mem_stall_i;

    always_comb begin
        exc_code  = 5'h00;
        bad_vaddr = 32'd0;
        if (take) begin
            if (int_pending)        exc_code = 5'h01;
            else if (mem_exc_i[0]) begin
                exc_code  = 5'h04;
                bad_vaddr = mem_pc_i;
            end
            else if (mem_exc_i[1])  exc_code = 5'h0a;
            else if (mem_exc_i[2])  exc_code = 5'h0c;
            else if (mem_exc_i[3])  exc_code = 5'h0d;
            else if (mem_exc_i[4])  exc_code = 5'h08;
            else if (mem_exc_i[5])  exc_code = 5'h09;
            else if (mem_exc_i[6]) begin
                exc_code  = 5'h04;
                bad_vaddr = mem_daddr_i;
            end
            else if (mem_exc_i[7]) begin
                exc_code  = 5'h05;
                bad_vaddr = mem_daddr_i;
            end
            else if (mem_eret_i)    exc_code = 5'h0e;
        end
    end

    assign new_pc_d = (exc_code == 5'h0e) ? eff_epc : EXC_VECTOR;

    // One capture per exception; REDIRECT blocks further captures until fetch accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            new_pc_valid_q <= 1'b0;
            new_pc_q       <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exc_code != 5'h00) begin
                        state_q        <= REDIRECT;
                        new_pc_valid_q <= 1'b1;
                        new_pc_q       <= new_pc_d;
                    end
                end
                REDIRECT: begin
                    if (new_pc_ready_i) begin
                        state_q        <= IDLE;
                        new_pc_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign excepttype_o      = {27'd0, exc_code};
    assign bad_vaddr_o       = bad_vaddr;
    assign pc_o              = rst ? mem_pc_i : 32'd0;
    assign is_in_delayslot_o = rst & mem_in_delayslot_i;
    assign flush_o           = (exc_code != 5'h00) | (state_q == REDIRECT);
    assign new_pc_valid_o    = new_pc_valid_q;
    assign new_pc_o          = new_pc_q;

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Randomized and directed bench for except_ctrl against a rule-level model.
module tb_except_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_hw_i;
    logic [5:0]  int_o;
    logic        mem_valid_i, mem_stall_i, mem_in_delayslot_i, mem_eret_i;
    logic [31:0] mem_pc_i, mem_daddr_i;
    logic [7:0]  mem_exc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i, status_i, cause_i, epc_i;
    logic [31:0] excepttype_o, pc_o, bad_vaddr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, new_pc_valid_o, new_pc_ready_i;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .int_hw_i(int_hw_i), .int_o(int_o),
        .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_exc_i(mem_exc_i),
        .mem_eret_i(mem_eret_i), .mem_daddr_i(mem_daddr_i),
        .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .excepttype_o(excepttype_o), .pc_o(pc_o), .bad_vaddr_o(bad_vaddr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o),
        .new_pc_valid_o(new_pc_valid_o), .new_pc_o(new_pc_o),
        .new_pc_ready_i(new_pc_ready_i)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: a redirect is outstanding or not, its target, and a delay line for the interrupts.
    bit          m_busy;
    logic [31:0] m_target;
    logic [5:0]  m_hist[$];
    logic [4:0]  e_code;
    logic [31:0] e_bad, e_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_target = 32'd0;
        m_hist   = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(6'd0);
    endtask

    task automatic compute_expect();
        int          codes[8] = '{4, 10, 12, 13, 8, 9, 4, 5};
        logic [31:0] st, cs;
        bit          pend, found;
        st    = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
        cs    = cause_i;
        if (cp0_we_i && cp0_waddr_i == 5'd13) cs[9:8] = cp0_wdata_i[9:8];
        e_epc = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
        pend  = st[0] && !st[1] && ((cs[15:8] & st[15:8]) != 8'd0);
        e_code = 5'd0;
        e_bad  = 32'd0;
        if (rst && !m_busy && mem_valid_i && !mem_stall_i) begin
            if (pend) e_code = 5'd1;
            else begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (!found && mem_exc_i[i]) begin
                        found  = 1'b1;
                        e_code = 5'(codes[i]);
                        if (i == 0) e_bad = mem_pc_i;
                        else if (i >= 6) e_bad = mem_daddr_i;
                    end
                end
                if (!found && mem_eret_i) e_code = 5'd14;
            end
        end
    endtask

    task automatic check();
        compute_expect();
        chk("excepttype", excepttype_o, {27'd0, e_code});
        chk("flush", 32'(flush_o), 32'((e_code != 5'd0) || m_busy));
        chk("new_pc_valid", 32'(new_pc_valid_o), 32'(m_busy));
        chk("new_pc", new_pc_o, m_target);
        chk("int_o", 32'(int_o), 32'(m_hist[0]));
        if (rst && e_code != 5'd0) begin
            chk("pc_o", pc_o, mem_pc_i);
            chk("delayslot", 32'(is_in_delayslot_o), 32'(mem_in_delayslot_i));
        end
        if (rst && (e_code == 5'd4 || e_code == 5'd5)) chk("bad_vaddr", bad_vaddr_o, e_bad);
        if (!rst) begin
            chk("rst_bad_vaddr", bad_vaddr_o, 32'd0);
            chk("rst_pc_o", pc_o, 32'd0);
            chk("rst_delayslot", 32'(is_in_delayslot_o), 32'd0);
        end
    endtask

    task automatic update_model();
        if (!rst) return;
        compute_expect();
        if (m_busy) begin
            if (new_pc_ready_i) m_busy = 1'b0;
        end else if (e_code != 5'd0) begin
            m_busy   = 1'b1;
            m_target = (e_code == 5'd14) ? e_epc : VEC;
        end
        m_hist.push_back(int_hw_i);
        void'(m_hist.pop_front());
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        #1 check();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        int_hw_i = 6'd0; mem_valid_i = 1'b0; mem_stall_i = 1'b0; mem_pc_i = 32'd0;
        mem_in_delayslot_i = 1'b0; mem_exc_i = 8'd0; mem_eret_i = 1'b0; mem_daddr_i = 32'd0;
        cp0_we_i = 1'b0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'd0;
        status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0; new_pc_ready_i = 1'b0;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic randomize_inputs();
        int sel;
        mem_valid_i        = ($urandom_range(0, 3) != 0);
        mem_stall_i        = ($urandom_range(0, 3) == 0);
        mem_pc_i           = $urandom;
        mem_in_delayslot_i = 1'($urandom_range(0, 1));
        for (int b = 0; b < 8; b++) mem_exc_i[b] = ($urandom_range(0, 7) == 0);
        mem_eret_i         = ($urandom_range(0, 7) == 0);
        mem_daddr_i        = $urandom;
        cp0_we_i           = ($urandom_range(0, 3) == 0);
        sel                = $urandom_range(0, 3);
        cp0_waddr_i        = (sel == 3) ? 5'($urandom_range(0, 31)) : 5'(12 + sel);
        cp0_wdata_i        = $urandom;
        status_i           = $urandom;
        cause_i            = $urandom;
        epc_i              = $urandom;
        int_hw_i           = 6'($urandom);
        new_pc_ready_i     = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        mem_valid_i = 1'b1;
        mem_exc_i   = 8'h10;
        int_hw_i    = 6'h3f;
        @(negedge clk);
        #1;
        chk("reset_excepttype", excepttype_o, 32'd0);
        chk("reset_flush", 32'(flush_o), 32'd0);
        chk("reset_valid", 32'(new_pc_valid_o), 32'd0);
        chk("reset_new_pc", new_pc_o, 32'd0);
        chk("reset_int_o", 32'(int_o), 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;

        // Syscall, then hold the redirect with ready low.
        mem_valid_i = 1'b1; mem_pc_i = 32'hBFC00100; mem_exc_i = 8'h10;
        #1;
        chk("sys_type", excepttype_o, 32'h08);
        chk("sys_pc", pc_o, 32'hBFC00100);
        chk("sys_flush", 32'(flush_o), 32'd1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sys_hold_valid", 32'(new_pc_valid_o), 32'd1);
            chk("sys_hold_target", new_pc_o, 32'hBFC00380);
            chk("sys_no_nested", excepttype_o, 32'd0);
            cycle();
        end
        new_pc_ready_i = 1'b1;
        cycle();
        clear_inputs();
        #1 chk("sys_done_valid", 32'(new_pc_valid_o), 32'd0);
        chk("sys_done_flush", 32'(flush_o), 32'd0);
        cycle();

        // Store address error in a delay slot.
        mem_valid_i = 1'b1; mem_pc_i = 32'h80001004; mem_in_delayslot_i = 1'b1;
        mem_daddr_i = 32'h80002001; mem_exc_i = 8'h80;
        #1;
        chk("ades_type", excepttype_o, 32'h05);
        chk("ades_bad", bad_vaddr_o, 32'h80002001);
        chk("ades_ds", 32'(is_in_delayslot_o), 32'd1);
        cycle();
        clear_inputs(); new_pc_ready_i = 1'b1;
        cycle();

        // ERET with a forwarded EPC write.
        clear_inputs();
        mem_valid_i = 1'b1; mem_eret_i = 1'b1; epc_i = 32'h1000;
        cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h2000;
        #1 chk("eret_type", excepttype_o, 32'h0e);
        cycle();
        clear_inputs();
        #1 chk("eret_target", new_pc_o, 32'h2000);
        new_pc_ready_i = 1'b1;
        cycle();

        // Interrupt synchronizer and interrupt masking cases.
        clear_inputs();
        status_i = 32'h0000FF01; int_hw_i = 6'b000001;
        cycle();
        #1 chk("sync_one_edge", 32'(int_o), 32'd0);
        cycle();
        #1 chk("sync_two_edges", 32'(int_o), 32'd1);
        cause_i = 32'h400; mem_valid_i = 1'b1;
        #1 chk("int_type", excepttype_o, 32'h01);
        cycle();
        mem_valid_i = 1'b0; new_pc_ready_i = 1'b1;
        cycle();
        new_pc_ready_i = 1'b0; mem_valid_i = 1'b1; status_i = 32'h0000FF03;
        #1 chk("int_exl_masked", excepttype_o, 32'd0);
        cycle();
        status_i = 32'h0000FF01; cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000FF00;
        #1 chk("int_mtc0_clears_ie", excepttype_o, 32'd0);
        cycle();
        cp0_we_i = 1'b0; mem_eret_i = 1'b1; epc_i = 32'h1234;
        #1 chk("int_over_eret", excepttype_o, 32'h01);
        cycle();
        clear_inputs();
        #1 chk("int_over_eret_target", new_pc_o, 32'hBFC00380);
        new_pc_ready_i = 1'b1;
        cycle();

        // Stall hides RI+Ov until it clears.
        clear_inputs();
        mem_valid_i = 1'b1; mem_exc_i = 8'h06; mem_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("stall_type", excepttype_o, 32'd0);
            chk("stall_flush", 32'(flush_o), 32'd0);
            cycle();
        end
        mem_stall_i = 1'b0;
        #1 chk("stall_release_type", excepttype_o, 32'h0a);
        cycle();
        clear_inputs(); new_pc_ready_i = 1'b1;
        cycle();

        // Trap, then reset in the middle of the redirect.
        clear_inputs();
        mem_valid_i = 1'b1; mem_exc_i = 8'h08;
        #1 chk("trap_type", excepttype_o, 32'h0d);
        cycle();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_valid", 32'(new_pc_valid_o), 32'd0);
        chk("rst_mid_flush", 32'(flush_o), 32'd0);
        chk("rst_mid_type", excepttype_o, 32'd0);
        chk("rst_mid_new_pc", new_pc_o, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1 chk("post_rst_valid", 32'(new_pc_valid_o), 32'd0);
        cycle();
        mem_valid_i = 1'b1; mem_exc_i = 8'h10;
        #1 chk("post_rst_take", excepttype_o, 32'h08);
        cycle();
        clear_inputs(); new_pc_ready_i = 1'b1;
        cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            randomize_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception initiator for the CP0 register block; sits at the MEM stage.
- Collects per-instruction exception flags and synchronizes the external interrupt lines, using forwarded CP0 state.
- Drives the excepttype/pc/bad_vaddr/delay-slot interface into CP0.
- Flushes the pipeline and issues the redirect target (exception vector or EPC for ERET) to fetch over a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry address.
- SYNC_STAGES, 2, flop depth of the interrupt-line synchronizer (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- int_hw_i  in  6  raw external interrupt lines
- int_o  out  6  synchronized interrupt lines to CP0 int_i
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_stall_i  in  1  MEM stage stalled this cycle
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- mem_exc_i  in  8  flags: [0]AdEL-fetch [1]RI [2]Ov [3]Trap [4]Syscall [5]Break [6]AdEL-data [7]AdES
- mem_eret_i  in  1  MEM instruction is ERET
- mem_daddr_i  in  32  data access address
- cp0_we_i / cp0_waddr_i / cp0_wdata_i  in  1/5/32  MTC0 write in flight this cycle (forwarding)
- status_i / cause_i / epc_i  in  32 each  CP0 register outputs
- excepttype_o  out  32  to CP0 excepttype_i
- pc_o  out  32  to CP0 pc_i
- bad_vaddr_o  out  32  to CP0 bad_vaddr_i
- is_in_delayslot_o  out  1  to CP0 is_in_delayslot_i
- flush_o  out  1  flush IF..MEM
- new_pc_valid_o  out  1  redirect valid
- new_pc_o  out  32  redirect target
- new_pc_ready_i  in  1  fetch accepts redirect

Behaviour:
- Reset (rst=0, async): state IDLE; synchronizer flops 0; new_pc_o=0; all outputs 0.
- Synchronizer: int_o = int_hw_i delayed SYNC_STAGES cycles.
- Forwarding, applies when cp0_we_i and the address matches:
  - eff_status = cp0_wdata_i for STATUS (12), else status_i.
  - eff_epc = cp0_wdata_i for EPC (14), else epc_i.
  - eff_cause = cause_i with bits [9:8] replaced by wdata[9:8] for CAUSE (13).
- int_pending = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]).
- take = (state==IDLE) & mem_valid_i & ~mem_stall_i.
- excepttype_o when take, first match wins, else 0:
  - int_pending → 0x01
  - AdEL-fetch → 0x04
  - RI → 0x0a
  - Ov → 0x0c
  - Trap → 0x0d
  - Syscall → 0x08
  - Break → 0x09
  - AdEL-data → 0x04
  - AdES → 0x05
  - mem_eret_i → 0x0e
- bad_vaddr_o: mem_pc_i for AdEL-fetch; mem_daddr_i for AdEL/AdES-data; else 0.
- pc_o = mem_pc_i and is_in_delayslot_o = mem_in_delayslot_i; both combinational, meaningful only when excepttype_o≠0.
- flush_o combinational: (excepttype_o≠0) | (state==REDIRECT).
- FSM:
  - IDLE → REDIRECT on excepttype_o≠0.
  - On that edge, new_pc_o registers EXC_VECTOR, or eff_epc if the type is 0x0e.
  - REDIRECT: new_pc_valid_o=1; new_pc_o held stable; excepttype_o forced 0 (no nested capture).
  - REDIRECT → IDLE on the edge where new_pc_ready_i=1; new_pc_valid_o drops the next cycle.
- Each exception produces exactly one excepttype_o cycle; CP0 samples it on that edge.
- Minimum exception-to-exception spacing is 2 cycles (detect + redirect with ready=1).
- mem_stall_i=1 in IDLE: no take; all CP0-side outputs 0 until the stall clears.
- Simultaneous MTC0 STATUS clearing IE and pending interrupt: the forwarded value wins, so no interrupt is taken.
- Simultaneous int_pending and ERET: interrupt wins; new_pc_o = EXC_VECTOR.
- Reset asserted during REDIRECT: immediate IDLE; new_pc_valid_o=0 with no handshake.

Test Plan:
- Syscall at mem_pc=0xBFC00100, not in delay slot → one cycle excepttype=0x08, pc_o=0xBFC00100, flush=1; next cycle new_pc_valid=1, new_pc=0xBFC00380; hold 3 cycles with ready=0, target stable; ready=1 → IDLE.
- AdES at pc=0x80001004, in delay slot, daddr=0x80002001 → excepttype=0x05, bad_vaddr=0x80002001, is_in_delayslot=1.
- ERET with epc_i=0x1000 and same-cycle MTC0 EPC=0x2000 → excepttype=0x0e, new_pc=0x2000.
- status=0x0000FF01, int_hw=6'b000001 → int_o[0] high after 2 cycles; cause[10] set with a valid instruction → excepttype=0x01; with status[1]=1 → no exception.
- RI and Ov flags together plus mem_stall_i=1 for 2 cycles → excepttype=0 while stalled, then 0x0a.
- Trap detected, rst pulled low during REDIRECT → outputs 0 immediately, FSM in IDLE after release.
